// File: rtl/flit_multi_injector.sv
// Multi-channel flit injector: per-channel FIFOs feed one Hermes credit-based
// local port through a packet-granular round-robin arbiter.
module flit_multi_injector #(
  parameter int FLIT_SIZE  = 32,
  parameter int N_CH       = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_CH-1:0]           ch_valid_i,
  output logic [N_CH-1:0]           ch_ready_o,
  input  logic [N_CH-1:0]           ch_last_i,
  input  logic [N_CH*FLIT_SIZE-1:0] ch_data_i,
  output logic                      tx_o,
  input  logic                      credit_i,
  output logic [FLIT_SIZE-1:0]      data_o,
  output logic                      eop_o,
  output logic                      busy_o,
  output logic [N_CH*CNT_W-1:0]     pkt_count_o,
  output logic                      dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Handshakes: a channel flit moves when ch_valid_i && ch_ready_o on a rising
  // edge; an output flit moves when tx_o && credit_i on a rising edge.

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               state;
  logic [CW-1:0]        grant;
  logic [CW-1:0]        rr_ptr;
  logic [CW-1:0]        pick;
  logic [CW-1:0]        next_rr;
  logic [CW:0]          arb_sum;
  logic                 found;
  logic [FLIT_SIZE:0]   mem [N_CH][FIFO_DEPTH];
  logic [AW:0]          wr_ptr [N_CH];
  logic [AW:0]          rd_ptr [N_CH];
  logic [N_CH-1:0]      empty;
  logic [N_CH-1:0]      full;
  logic [N_CH-1:0]      push;
  logic [N_CH-1:0]      pop;
  logic [CNT_W-1:0]     pkt_count [N_CH];
  logic [FLIT_SIZE:0]   head;
  logic                 send_ok;
  logic                 xfer;

  always_comb begin
    head    = mem[grant][rd_ptr[grant][AW-1:0]];
    send_ok = (state == SEND) && !empty[grant];
    xfer    = send_ok && credit_i;
  end

  always_comb begin
    empty = '0;
    full  = '0;
    push  = '0;
    pop   = '0;
    for (int c = 0; c < N_CH; c++) begin
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
      // Extra pointer bit distinguishes full from empty at equal addresses.
      full[c]  = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                 (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
      push[c]  = ch_valid_i[c] && !full[c];
      pop[c]   = xfer && (grant == CW'(c));
    end
  end

  // First non-empty channel at or after rr_ptr, wrapping modulo N_CH.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    arb_sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      arb_sum = {1'b0, rr_ptr} + (CW+1)'(i);
      if (arb_sum >= (CW+1)'(N_CH)) arb_sum = arb_sum - (CW+1)'(N_CH);
      if (!found && !empty[arb_sum[CW-1:0]]) begin
        found = 1'b1;
        pick  = arb_sum[CW-1:0];
      end
    end
  end

  always_comb begin
    next_rr = (int'(grant) == N_CH - 1) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < N_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c][AW-1:0]] <= {ch_last_i[c], ch_data_i[c*FLIT_SIZE +: FLIT_SIZE]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      for (int c = 0; c < N_CH; c++) begin
        wr_ptr[c]    <= '0;
        rd_ptr[c]    <= '0;
        pkt_count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
      end
      case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            state <= SEND;
          end
        end
        SEND: begin
          // The grant is held through empty cycles until the last flit leaves.
          if (xfer && head[FLIT_SIZE]) begin
            pkt_count[grant] <= pkt_count[grant] + 1'b1;
            rr_ptr           <= next_rr;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ch_ready_o  = ~full;
    tx_o        = send_ok;
    data_o      = send_ok ? head[FLIT_SIZE-1:0] : '0;
    eop_o       = send_ok && head[FLIT_SIZE];
    busy_o      = (state == SEND) || !(&empty);
    dbg_state   = (state == SEND);
    pkt_count_o = '0;
    for (int c = 0; c < N_CH; c++) pkt_count_o[c*CNT_W +: CNT_W] = pkt_count[c];
  end

endmodule

// File: tb/tb_flit_multi_injector.sv
// Directed and randomized bench for flit_multi_injector, checked every cycle
// against a queue-based packet model of the injector.
module tb_flit_multi_injector;

  localparam int FS    = 32;
  localparam int NC    = 2;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  typedef logic [FS:0] flit_t;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NC-1:0]       ch_valid_i;
  logic [NC-1:0]       ch_ready_o;
  logic [NC-1:0]       ch_last_i;
  logic [NC*FS-1:0]    ch_data_i;
  logic                tx_o;
  logic                credit_i;
  logic [FS-1:0]       data_o;
  logic                eop_o;
  logic                busy_o;
  logic [NC*CW-1:0]    pkt_count_o;
  logic                dbg_state;

  flit_multi_injector #(
    .FLIT_SIZE(FS), .N_CH(NC), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ch_valid_i(ch_valid_i), .ch_ready_o(ch_ready_o),
    .ch_last_i(ch_last_i), .ch_data_i(ch_data_i),
    .tx_o(tx_o), .credit_i(credit_i), .data_o(data_o), .eop_o(eop_o),
    .busy_o(busy_o), .pkt_count_o(pkt_count_o), .dbg_state(dbg_state)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: producer queues, per-channel FIFO contents, packet owner.
  flit_t         src [NC][$];
  flit_t         mq  [NC][$];
  logic [FS-1:0] exp_q[$];
  logic [FS-1:0] got_q[$];
  bit            m_in_pkt;
  int            m_cur;
  int            m_rr;
  int            m_cnt [NC];
  int            gen_pkts [NC];
  int            n_cmp;
  int            n_fail;

  function automatic flit_t mk(input logic last, input logic [FS-1:0] d);
    return {last, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < NC; c++) begin
      mq[c].delete();
      src[c].delete();
      m_cnt[c] = 0;
    end
    m_in_pkt = 0;
    m_cur    = 0;
    m_rr     = 0;
  endfunction

  function automatic bit model_busy();
    bit b;
    b = m_in_pkt;
    for (int c = 0; c < NC; c++) if (src[c].size() > 0 || mq[c].size() > 0) b = 1;
    return b;
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input bit rst_v, input bit credit_v, input int gate_pct);
    bit    vld [NC];
    bit    acc [NC];
    bit    exp_tx;
    bit    exp_busy;
    flit_t f;
    rst_ni   = rst_v;
    credit_i = credit_v;
    for (int c = 0; c < NC; c++) begin
      vld[c] = (src[c].size() > 0) && ($urandom_range(0, 99) < gate_pct);
      ch_valid_i[c] = vld[c];
      if (src[c].size() > 0) begin
        ch_last_i[c] = src[c][0][FS];
        ch_data_i[c*FS +: FS] = src[c][0][FS-1:0];
      end else begin
        ch_last_i[c] = 1'b0;
        ch_data_i[c*FS +: FS] = $urandom;
      end
    end
    exp_tx   = m_in_pkt && (mq[m_cur].size() > 0);
    exp_busy = m_in_pkt;
    for (int c = 0; c < NC; c++) if (mq[c].size() > 0) exp_busy = 1;
    #1;
    if (rst_v) begin
      chk("tx", tx_o, exp_tx);
      if (exp_tx) begin
        chk("data", data_o, mq[m_cur][0][FS-1:0]);
        chk("eop", eop_o, mq[m_cur][0][FS]);
      end
      chk("busy", busy_o, exp_busy);
      for (int c = 0; c < NC; c++) begin
        chk("ready", ch_ready_o[c], mq[c].size() < DEPTH);
        chk("pkt_count", pkt_count_o[c*CW +: CW], 64'(m_cnt[c] & 32'hFFFF));
      end
      if (tx_o && credit_v) got_q.push_back(data_o);
    end
    @(posedge clk_i);
    if (!rst_v) begin
      model_clear();
    end else begin
      for (int c = 0; c < NC; c++) acc[c] = vld[c] && (mq[c].size() < DEPTH);
      if (exp_tx && credit_v) begin
        f = mq[m_cur].pop_front();
        if (f[FS]) begin
          m_cnt[m_cur]++;
          m_rr     = (m_cur + 1) % NC;
          m_in_pkt = 0;
        end
      end else if (!m_in_pkt) begin
        for (int i = 0; i < NC; i++) begin
          int ch = (m_rr + i) % NC;
          if (!m_in_pkt && mq[ch].size() > 0) begin
            m_cur    = ch;
            m_in_pkt = 1;
          end
        end
      end
      for (int c = 0; c < NC; c++) if (acc[c]) mq[c].push_back(src[c].pop_front());
    end
    @(negedge clk_i);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_tx"}, tx_o, 0);
    chk({tag, "_eop"}, eop_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ready"}, ch_ready_o, {NC{1'b1}});
    chk({tag, "_cnt"}, pkt_count_o, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    got_q.delete();
    reset_check("reset");
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < got_q.size()) ? 64'(got_q[i]) : 64'hDEAD_0000_0000, exp_q[i]);
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst_ni     = 1'b0;
    credit_i   = 1'b0;
    ch_valid_i = '0;
    ch_last_i  = '0;
    ch_data_i  = '0;
    model_clear();
    do_reset();

    // Single 3-flit packet on ch0.
    src[0].push_back(mk(0, 32'h1));
    src[0].push_back(mk(0, 32'h2));
    src[0].push_back(mk(1, 32'h3));
    repeat (8) step(1, 1, 100);
    exp_q = '{32'h1, 32'h2, 32'h3};
    check_log("single");
    chk("single_cnt0", pkt_count_o[0 +: CW], 1);

    // Round-robin between two preloaded channels.
    do_reset();
    src[0].push_back(mk(0, 32'hA000)); src[0].push_back(mk(1, 32'hA001));
    src[0].push_back(mk(0, 32'hA100)); src[0].push_back(mk(1, 32'hA101));
    src[1].push_back(mk(0, 32'hB000)); src[1].push_back(mk(1, 32'hB001));
    src[1].push_back(mk(0, 32'hB100)); src[1].push_back(mk(1, 32'hB101));
    repeat (3) step(1, 0, 100);
    repeat (16) step(1, 1, 100);
    exp_q = '{32'hA000, 32'hA001, 32'hB000, 32'hB001,
              32'hA100, 32'hA101, 32'hB100, 32'hB101};
    check_log("rr");

    // Five cycles of backpressure mid-packet.
    do_reset();
    for (int i = 0; i < 4; i++) src[0].push_back(mk(i == 3, 32'hC0 + i));
    for (int i = 0; i < 16; i++) begin
      if (i >= 4 && i <= 9) begin
        chk("bp_tx", tx_o, 1);
        chk("bp_data", data_o, 32'hC2);
      end
      step(1, !(i >= 4 && i < 9), 100);
    end
    exp_q = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    check_log("bp");

    // FIFO full on ch1 with credit withheld.
    do_reset();
    for (int i = 0; i < 10; i++) src[1].push_back(mk(i == 9, 32'hD0 + i));
    repeat (10) step(1, 0, 100);
    chk("full_ready1", ch_ready_o[1], 0);
    repeat (20) step(1, 1, 100);
    exp_q = '{32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD4,
              32'hD5, 32'hD6, 32'hD7, 32'hD8, 32'hD9};
    check_log("full");

    // Starved grant: ch0 stalls mid-packet while ch1 waits with a full packet.
    do_reset();
    src[0].push_back(mk(0, 32'hE0));
    src[1].push_back(mk(0, 32'hF0));
    src[1].push_back(mk(0, 32'hF1));
    src[1].push_back(mk(1, 32'hF2));
    for (int i = 0; i < 7; i++) begin
      if (i >= 3) chk("starve_tx", tx_o, 0);
      step(1, 1, 100);
    end
    src[0].push_back(mk(0, 32'hE1));
    src[0].push_back(mk(1, 32'hE2));
    repeat (16) step(1, 1, 100);
    exp_q = '{32'hE0, 32'hE1, 32'hE2, 32'hF0, 32'hF1, 32'hF2};
    check_log("starve");

    // Reset while the second of four flits is on the port.
    do_reset();
    for (int i = 0; i < 4; i++) src[0].push_back(mk(i == 3, 32'h70 + i));
    repeat (3) step(1, 1, 100);
    chk("mid_rst_data", data_o, 32'h71);
    step(0, 1, 100);
    reset_check("mid_rst");
    repeat (10) step(1, 1, 100);
    exp_q = '{32'h70};
    check_log("mid_rst");

    // Randomized traffic on all channels with random credit and valid gaps.
    do_reset();
    for (int c = 0; c < NC; c++) gen_pkts[c] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        if (src[c].size() < 4) begin
          int len = $urandom_range(1, 5);
          for (int k = 0; k < len; k++) src[c].push_back(mk(k == len - 1, $urandom));
          gen_pkts[c]++;
        end
      end
      step(1, $urandom_range(0, 3) != 0, 70);
    end
    begin
      int k = 0;
      while (model_busy() && k < 600) begin
        step(1, 1, 100);
        k++;
      end
      chk("drain_done", k < 600, 1);
    end
    step(1, 1, 100);
    for (int c = 0; c < NC; c++)
      chk("rand_cnt", pkt_count_o[c*CW +: CW], 64'(gen_pkts[c] & 32'hFFFF));
    chk("rand_idle_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_multi_injector.md
# flit_multi_injector

Parametrised multi-channel packet injector for the Hermes credit-based local port, the generalised successor of the single-stream MA/application injectors. It accepts flits from N_CH independent valid/ready producers and buffers each channel in its own FIFO. A round-robin arbiter grants one channel per packet, so packets are never interleaved, and flits stream onto one tx/credit/data output. Per-channel sent-packet counters support bench-side end-of-injection checks.

## Interface
- FLIT_SIZE, 32: flit width in bits.
- N_CH, 2: number of input channels, 1..8.
- FIFO_DEPTH, 8: flits per channel FIFO, power of two, at least 2.
- CNT_W, 16: width of each packet counter.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset; synchronous and active-low.
- ch_valid_i  in  N_CH  per-channel flit valid.
- ch_ready_o  out  N_CH  per-channel FIFO not full.
- ch_last_i  in  N_CH  flit is the last of its packet.
- ch_data_i  in  N_CH*FLIT_SIZE  channel c occupies bits [c*FLIT_SIZE +: FLIT_SIZE].
- tx_o  out  1  output flit valid (Hermes rx side).
- credit_i  in  1  downstream can accept a flit.
- data_o  out  FLIT_SIZE  output flit.
- eop_o  out  1  data_o is the last flit of a packet; qualified by tx_o.
- busy_o  out  1  a packet is granted, or any FIFO is non-empty.
- pkt_count_o  out  N_CH*CNT_W  packets fully sent per channel.

## Operation
- Each FIFO entry is {last, data}.
- Input write: when ch_valid_i[c] && ch_ready_o[c].
- ch_ready_o[c] = !full[c]. It depends on FIFO occupancy only. A full FIFO refuses a write even in a cycle where it is popped.
- Output transfer happens when tx_o && credit_i. The granted FIFO pops on that edge.
- FSM states are IDLE and SEND.
  - IDLE: if any FIFO is non-empty, grant the first non-empty channel searching from rr_ptr upward, mod N_CH. Latch grant and go to SEND. Otherwise stay in IDLE.
  - SEND: tx_o = !empty[grant]. data_o and eop_o come from the head of FIFO[grant]. When a transfer carries last=1, increment pkt_count[grant], set rr_ptr = (grant+1) mod N_CH, and go to IDLE.
- An empty granted FIFO mid-packet drops tx_o but keeps the grant. Other channels wait.
- Flits of a packet always leave contiguously, in order, on the granted channel.
- Counters wrap modulo 2^CNT_W without saturating.
- A packet with no last flag holds the grant indefinitely; this is the producer's responsibility.
- When N_CH = 1, rr_ptr is always 0.

## Timing
- Reset (rst_ni low at a rising edge):
  - all FIFOs emptied, FSM set to IDLE, grant=0, rr_ptr=0, counters cleared;
  - tx_o=0, eop_o=0, data_o=0, busy_o=0, ch_ready_o all 1 in the first cycle after reset.
- Reset mid-packet truncates the packet; no further flits of it are emitted.
- Latency: a flit written at edge t into an empty FIFO while IDLE sees grant at edge t+1. tx_o goes high after t+1 and transfers at edge t+2 if credit_i=1.
- Minimum one-cycle IDLE gap between packets; tx_o=0 during the gap.
- Throughput within a packet is 1 flit/cycle while credit_i=1 and the FIFO is non-empty.
- While tx_o=1 and credit_i=0, data_o and eop_o hold stable. tx_o is not withdrawn until a transfer occurs.
- tx_o, data_o and eop_o are functions of registered state only. None has a combinational path from credit_i or ch_valid_i.
- Simultaneous write and pop on the same non-full FIFO: occupancy is unchanged and both take effect.
- pkt_count_o updates on the edge of the last-flit transfer.

## Test plan
- Single packet: N_CH=2, ch0 writes 3 flits 0x1,0x2,0x3 (last on the third), credit_i=1. Required: tx_o high for 3 consecutive cycles starting 2 cycles after the first write, eop_o only with 0x3, pkt_count[0]=1.
- Round-robin: ch0 and ch1 each preload two 2-flit packets (A0,A1,B0,B1). Required output order: A0, B0, A1, B1, with a one-cycle gap between packets and no interleaving inside a packet.
- Backpressure: hold credit_i=0 for 5 cycles mid-packet. Required: data_o is stable and tx_o=1 throughout; the packet completes after credit returns with no flit lost or duplicated.
- FIFO full: FIFO_DEPTH=8, credit_i=0, ch1 offers 10 flits. Required: ch_ready_o[1]=0 after 8 writes; the remaining 2 are accepted only after pops, and all 10 are emitted in order.
- Starved grant: ch0 sends the first flit of a packet, then stalls 4 cycles while ch1 holds a full packet. Required: tx_o=0 during the stall, ch1 is not emitted until ch0's last flit is sent.
- Reset mid-packet: assert rst_ni=0 during flit 2 of 4. Required: all outputs at reset values the next cycle, counters 0, and the remaining flits never appear.
